// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential signed/unsigned multiplier.
package seq_mult_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StRun  = ST_RUN
    } state_e;

endpackage

// File: rtl/mult_step.sv
// One combinational shift-add step: conditional add/subtract of the multiplicand, then shift right.
module mult_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic             sgn_i,
    input  logic             last_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] term;
    logic [WIDTH:0] sum;
    logic           sub;
    logic           cin;

    always_comb begin
        a_ext = {sgn_i & a_i[WIDTH-1], a_i};
        // The multiplier MSB carries negative weight in signed mode.
        sub   = sgn_i & last_i;
        term  = '0;
        cin   = 1'b0;
        if (lo_i[0]) begin
            term = sub ? ~a_ext : a_ext;
            cin  = sub;
        end
        sum  = hi_i + term + (WIDTH+1)'(cin);
        // Unsigned sums never exceed WIDTH+1 bits, so the top bit shifts in as zero.
        hi_o = {sgn_i & sum[WIDTH], sum[WIDTH:1]};
        lo_o = {sum[0], lo_i[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mult_sgn.sv
// Iterative shift-add multiplier, signed or unsigned per operation, with start/busy/done handshake.
module seq_mult_sgn
    import seq_mult_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_i,
    input  logic               sgn_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int unsigned CNTW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic               last;

    assign last = (cnt_q == CNTW'(WIDTH - 1));

    mult_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .hi_i   (hi_q),
        .lo_i   (lo_q),
        .a_i    (a_q),
        .sgn_i  (sgn_q),
        .last_i (last),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        sgn_d   = sgn_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    sgn_d   = sgn_i;
                    hi_d    = '0;
                    lo_d    = b_i;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + CNTW'(1);
                if (last) begin
                    prod_d  = {step_hi[WIDTH-1:0], step_lo};
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy_o    = (state_q == StRun);
    assign done_o    = done_q;
    assign product_o = prod_q;

endmodule
